// File: rtl/ni_rx_sync.sv
// Receive stage: QDI 1-of-4 flit input to a synchronous valid/ready FIFO output.
// Optional code checking (err output, lowest-rail decode) is enabled by defining NI_RX_CHECK_EN.
module ni_rx_sync #(
  parameter int unsigned DW    = 32,
  parameter int unsigned SCN   = DW / 2,
  parameter int unsigned FT    = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SYNC  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SCN-1:0]           di0,
  input  logic [SCN-1:0]           di1,
  input  logic [SCN-1:0]           di2,
  input  logic [SCN-1:0]           di3,
  input  logic [FT-1:0]            dit,
  output logic                     dia,
  output logic [DW-1:0]            dout,
  output logic [FT-1:0]            dout_ft,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StAck, StRtz} state_e;

  state_e           state_q;
  logic             dia_q;
  logic [SYNC-1:0]  full_sync_q, null_sync_q;
  logic             full_c, null_c, full_s, null_s;
  logic [DW-1:0]    dec_data;
  logic [FT-1:0]    dec_ft;
  logic             wr, rd, fifo_full;

  logic [DW-1:0]    mem_data [DEPTH];
  logic [FT-1:0]    mem_ft   [DEPTH];
  logic [LW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [FT-1:0]    dout_ft_q, dout_ft_d;
  logic             dout_vld_q;

  assign full_c = (&(di0 | di1 | di2 | di3)) & (|dit);
  assign null_c = ~(|{di0, di1, di2, di3, dit});
  assign full_s = full_sync_q[SYNC-1];
  assign null_s = null_sync_q[SYNC-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_sync_q <= '0;
      null_sync_q <= '0;
    end else begin
      full_sync_q <= {full_sync_q[SYNC-2:0], full_c};
      null_sync_q <= {null_sync_q[SYNC-2:0], null_c};
    end
  end

`ifdef NI_RX_CHECK_EN
  logic [SCN-1:0] multi_rail;
  logic           code_err;
  logic           err_q;

  always_comb begin
    dec_data   = '0;
    multi_rail = '0;
    for (int k = 0; k < SCN; k++) begin
      if (di0[k])      dec_data[2*k +: 2] = 2'd0;
      else if (di1[k]) dec_data[2*k +: 2] = 2'd1;
      else if (di2[k]) dec_data[2*k +: 2] = 2'd2;
      else             dec_data[2*k +: 2] = 2'd3;
      multi_rail[k] = (di0[k] & (di1[k] | di2[k] | di3[k])) | (di1[k] & (di2[k] | di3[k])) |
                      (di2[k] & di3[k]);
    end
    // Keep only the lowest set type bit.
    dec_ft   = dit & (~dit + FT'(1));
    code_err = (|multi_rail) | ((dit & (dit - FT'(1))) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_q <= 1'b0;
    else if (wr && code_err)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  always_comb begin
    dec_data = '0;
    for (int k = 0; k < SCN; k++) begin
      dec_data[2*k]   = di1[k] | di3[k];
      dec_data[2*k+1] = di2[k] | di3[k];
    end
    dec_ft = dit;
  end

  assign err = 1'b0;
`endif

  assign fifo_full = (level_q == LW'(DEPTH));
  assign wr        = (state_q == StIdle) && full_s && !fifo_full;
  assign rd        = dout_vld_q & dout_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dia_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (wr) begin
          state_q <= StAck;
          dia_q   <= 1'b1;
        end
        StAck: if (null_s) begin
          state_q <= StRtz;
          dia_q   <= 1'b0;
        end
        // One dead cycle so a stale full_s cannot cause a second capture.
        StRtz: state_q <= StIdle;
        default: begin
          state_q <= StIdle;
          dia_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data[wptr_q[AW-1:0]] <= dec_data;
      mem_ft[wptr_q[AW-1:0]]   <= dec_ft;
    end
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    level_d   = level_q;
    dout_d    = dout_q;
    dout_ft_d = dout_ft_q;
    if (wr) wptr_d = wptr_q + LW'(1);
    if (rd) rptr_d = rptr_q + LW'(1);
    if (wr && !rd)      level_d = level_q + LW'(1);
    else if (!wr && rd) level_d = level_q - LW'(1);
    if (level_d != '0) begin
      // The entry being written becomes head only when nothing else remains.
      if (wr && (level_q == LW'(rd))) begin
        dout_d    = dec_data;
        dout_ft_d = dec_ft;
      end else begin
        dout_d    = mem_data[rptr_d[AW-1:0]];
        dout_ft_d = mem_ft[rptr_d[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      dout_q     <= '0;
      dout_ft_q  <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      dout_q     <= dout_d;
      dout_ft_q  <= dout_ft_d;
      dout_vld_q <= (level_d != '0);
    end
  end

  assign dia      = dia_q;
  assign dout     = dout_q;
  assign dout_ft  = dout_ft_q;
  assign dout_vld = dout_vld_q;
  assign level    = level_q;

endmodule
